mips_avalon_master: RTL and testbench
=====================================

MIPS_AVALON_MASTER -- requirements
Module: mips_avalon_master

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 The block SHALL expose these parameters (name, default, meaning):
- TIMEOUT, 256: maximum consecutive waitrequest-high cycles before a transfer is aborted.
- ADDR_MASK_LOW, 1: 1 = drive the Avalon address with bits [1:0] cleared.

REQ-003 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- req_valid, in, 1: CPU access request.
- req_ready, out, 1: block can accept a request.
- req_we, in, 1: 1 = store, 0 = load.
- req_size, in, 2: 00 = byte, 01 = half, 10 = word; 11 is illegal.
- req_signed, in, 1: sign-extend load data.
- req_addr, in, 32: byte address.
- req_wdata, in, 32: store data, right-justified.
- resp_valid, out, 1: one-cycle completion pulse.
- resp_rdata, out, 32: extended load data.
- resp_err, out, 1: misaligned, illegal size or timeout.
- address, out, 32: Avalon address.
- read, out, 1: Avalon read strobe.
- write, out, 1: Avalon write strobe.
- writedata, out, 32: Avalon write data.
- byteenable, out, 4: Avalon byte lanes.
- waitrequest, in, 1: Avalon stall.
- readdata, in, 32: Avalon read data, valid in the cycle waitrequest is low.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, BUS and RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where req_valid=1 and req_ready=1.
REQ-006 On acceptance, the block SHALL check alignment:
- half requires addr[0]=0;
- word requires addr[1:0]=00;
- req_size=11 is illegal.
REQ-007 For an illegal or misaligned request, the block SHALL go to RESP with resp_err=1 and resp_rdata=0, and SHALL issue no bus cycle.
REQ-008 For a legal request, the block SHALL go to BUS; in the first BUS cycle (acceptance edge +1), read or write SHALL be asserted.
REQ-009 While in BUS, address, writedata, byteenable, read and write SHALL stay constant.
REQ-010 When ADDR_MASK_LOW=1, address SHALL be req_addr with bits [1:0] forced to 00; otherwise it SHALL equal req_addr.
REQ-011 Byte-lane mapping is little-endian, off = req_addr[1:0]:
- byte: byteenable = 0001 << off;
- half: byteenable = 0011 << off;
- word: byteenable = 1111.
REQ-012 For stores, writedata SHALL be:
- byte: req_wdata[7:0] replicated to all 4 lanes;
- half: req_wdata[15:0] replicated to both halves;
- word: req_wdata unchanged.
REQ-013 For loads, writedata SHALL be 0 and byteenable SHALL follow REQ-011.
REQ-014 A BUS cycle with waitrequest=0 completes the transfer; on a load, readdata SHALL be captured on that edge.
REQ-015 On completion, read and write SHALL drop at the next edge and the state SHALL move to RESP.
REQ-016 Load extraction SHALL work as follows:
- byte: take readdata[8*off+7 : 8*off];
- half: take readdata[16*off[1]+15 : 16*off[1]];
- word: take readdata unchanged;
- extend with sign when req_signed=1, else with zeros.
req_signed SHALL be ignored for word loads.
REQ-017 In RESP, resp_valid SHALL be 1 for exactly one cycle, after which the state SHALL return to IDLE.
REQ-018 resp_rdata and resp_err SHALL be valid only while resp_valid=1 and SHALL be held at 0 otherwise.
REQ-019 For stores, resp_rdata SHALL be 0.
REQ-020 A wait counter SHALL reset to 0 on entering BUS and SHALL increment on each BUS cycle with waitrequest=1.
REQ-021 If the wait counter reaches TIMEOUT, the block SHALL abort: read and write drop at the next edge, then RESP with resp_err=1 and resp_rdata=0.
REQ-022 A waitrequest low in the same cycle the counter hits TIMEOUT SHALL count as success, with no error.
REQ-023 Best-case load latency SHALL be 3 cycles from the acceptance edge to resp_valid high (BUS with waitrequest=0 on the first cycle, then RESP); each waitrequest-high cycle SHALL add one cycle.
REQ-024 The block SHALL keep only one outstanding transfer; req_valid SHALL be ignored outside IDLE.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE and clear the wait counter, including mid-transfer.
REQ-026 After that edge, the outputs SHALL be:
- read=0, write=0;
- address=0, writedata=0, byteenable=0;
- resp_valid=0, resp_rdata=0, resp_err=0;
- req_ready=1.
REQ-027 A transfer interrupted by reset SHALL produce no resp_valid.

Verification
REQ-028 Word load: addr=0xBFC00004, slave holds 0xDEADBEEF with 2 wait cycles -> address=0xBFC00004, byteenable=1111, resp_rdata=0xDEADBEEF, resp_err=0, latency 5 cycles.
REQ-029 Signed byte load: addr=0xBFC00003, readdata=0x80112233 -> byteenable=1000, resp_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-030 Half store: addr=0xBFC00002, wdata=0x0000ABCD -> write=1, byteenable=1100, writedata=0xABCDABCD, resp_valid pulse with resp_err=0.
REQ-031 Misaligned word store at 0xBFC00001 -> no read/write asserted, resp_valid one cycle after acceptance, resp_err=1.
REQ-032 Timeout: TIMEOUT=8, waitrequest held high -> read drops after 8 wait cycles, resp_err=1, resp_rdata=0; next request is accepted normally.
REQ-033 Reset asserted during BUS with waitrequest high -> read=0 and req_ready=1 after the edge, no resp_valid.

Source files
------------

// File: rtl/mips_avalon_master.sv
// mips_avalon_master: MIPS load/store port to Avalon-MM master bridge with lane steering, load extension and wait timeout
module mips_avalon_master #(
   parameter int TIMEOUT       = 256,
   parameter int ADDR_MASK_LOW = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);
   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [1:0] off, size;
   logic sgn, we, err;
   logic [31:0] rdata, wd_nx, ext;
   logic [3:0] be_nx;
   logic [7:0] b;
   logic [15:0] h;
   logic accept, bad, done, abort;
   assign req_ready  = state == IDLE;
   assign accept     = req_valid && req_ready;
   assign bad        = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
   assign done       = state == BUS && !waitrequest;
   assign abort      = state == BUS && waitrequest && cnt == CW'(TIMEOUT);
   assign resp_valid = state == RESP;
   assign resp_rdata = resp_valid ? rdata : 32'h0;
   assign resp_err   = resp_valid && err;
   assign be_nx = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] :
                  req_size == 2'b01 ? 4'b0011 << req_addr[1:0] : 4'b1111;
   assign wd_nx = !req_we ? 32'h0 :
                  req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                  req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
   assign b   = readdata[{off, 3'b000} +: 8];
   assign h   = readdata[{off[1], 4'b0000} +: 16];
   assign ext = size == 2'b00 ? {{24{sgn && b[7]}}, b} :
                size == 2'b01 ? {{16{sgn && h[15]}}, h} : readdata;
   always_comb begin
      state_nx = state;
      if (state == IDLE && accept)
         state_nx = bad ? RESP : BUS;
      else if (done || abort)
         state_nx = RESP;
      else if (state == RESP)
         state_nx = IDLE;
   end
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nx;
   // bus signals are loaded once at acceptance, which keeps them stable for the whole BUS phase
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         off        <= '0;
         size       <= '0;
         sgn        <= 1'b0;
         we         <= 1'b0;
         err        <= 1'b0;
         rdata      <= '0;
         address    <= '0;
         writedata  <= '0;
         byteenable <= '0;
         read       <= 1'b0;
         write      <= 1'b0;
      end else begin
         if (accept) begin
            off   <= req_addr[1:0];
            size  <= req_size;
            sgn   <= req_signed;
            we    <= req_we;
            err   <= bad;
            rdata <= '0;
            cnt   <= '0;
            if (!bad) begin
               address    <= ADDR_MASK_LOW != 0 ? {req_addr[31:2], 2'b00} : req_addr;
               byteenable <= be_nx;
               writedata  <= wd_nx;
               read       <= !req_we;
               write      <= req_we;
            end
         end
         if (state == BUS && waitrequest)
            cnt <= cnt + 1'b1;
         if (done || abort) begin
            read  <= 1'b0;
            write <= 1'b0;
            err   <= abort;
            rdata <= done && !we ? ext : 32'h0;
         end
      end
   end
endmodule

// File: tb/tb_mips_avalon_master.sv
// tb_mips_avalon_master: randomized transactions against a transaction-level model with a scripted Avalon slave
module tb_mips_avalon_master;
   localparam int TO = 8;
   logic clk = 0, rst = 1;
   logic req_valid = 0, req_we = 0, req_signed = 0;
   logic [1:0] req_size = 0;
   logic [31:0] req_addr = 0, req_wdata = 0, readdata = 0;
   logic waitrequest = 1;
   logic req_ready, resp_valid, resp_err, read, write;
   logic [31:0] resp_rdata, address, writedata;
   logic [3:0] byteenable;
   int n_cmp = 0, n_bad = 0;

   mips_avalon_master #(.TIMEOUT(TO), .ADDR_MASK_LOW(1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .address(address),
      .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
      .waitrequest(waitrequest), .readdata(readdata));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // one request end to end; latency counts the acceptance cycle as cycle 1
   task automatic xfer(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input int waits, input logic [31:0] rd);
      logic bad, eerr;
      logic [3:0] be;
      logic [31:0] ewd, ea, erd;
      int off, elat, ebus, n, busc;
      bit seen;
      off = int'(a[1:0]);
      bad = (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
      be  = sz == 0 ? 4'(1 << off) : sz == 1 ? 4'(3 << off) : 4'hF;
      ewd = !we ? 0 : sz == 0 ? 32'(a * 0 + wd[7:0]) * 32'h01010101 :
            sz == 1 ? 32'(wd[15:0]) * 32'h00010001 : wd;
      ea  = a & ~32'h3;
      erd = sz == 0 ? (rd >> (8 * off)) & 32'hFF : sz == 1 ? (rd >> (off >= 2 ? 16 : 0)) & 32'hFFFF : rd;
      if (sg && sz == 0 && erd >= 128) erd = erd - 256;
      if (sg && sz == 1 && erd >= 32768) erd = erd - 65536;
      if (we) erd = 0;
      if (bad) begin ebus = 0; elat = 2; eerr = 1; erd = 0; end
      else if (waits > TO) begin ebus = TO + 1; elat = TO + 3; eerr = 1; erd = 0; end
      else begin ebus = waits + 1; elat = waits + 3; eerr = 0; end
      chk("ready_before", {31'b0, req_ready}, 1);
      req_valid = 1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
      n = 2; busc = 0; seen = 0;
      while (n < 60 && !seen) begin
         if (resp_valid) begin
            seen = 1;
            chk("latency", n, elat);
            chk("resp_err", {31'b0, resp_err}, {31'b0, eerr});
            chk("resp_rdata", resp_rdata, erd);
            chk("strobes_in_resp", {30'b0, read, write}, 0);
         end else begin
            if (read || write) begin
               chk("read", {31'b0, read}, {31'b0, !we});
               chk("write", {31'b0, write}, {31'b0, we});
               chk("address", address, ea);
               chk("byteenable", {28'b0, byteenable}, {28'b0, be});
               chk("writedata", writedata, ewd);
               waitrequest = busc < waits;
               readdata = busc < waits ? $urandom : rd;
               busc++;
            end else waitrequest = 1;
            chk("resp_rdata_idle", resp_rdata, 0);
            chk("resp_err_idle", {31'b0, resp_err}, 0);
            @(posedge clk); #1;
            n++;
         end
      end
      if (!seen) chk("resp_seen", 0, 1);
      chk("bus_cycles", busc, ebus);
      waitrequest = 1;
      @(posedge clk); #1;
      chk("resp_one_cycle", {31'b0, resp_valid}, 0);
      chk("ready_after", {31'b0, req_ready}, 1);
      chk("rdata_after", resp_rdata, 0);
   endtask

   initial begin
      int cnt_rv;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      chk("rst_read", {31'b0, read}, 0);
      chk("rst_write", {31'b0, write}, 0);
      chk("rst_address", address, 0);
      chk("rst_writedata", writedata, 0);
      chk("rst_be", {28'b0, byteenable}, 0);
      chk("rst_resp", {30'b0, resp_valid, resp_err}, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_ready", {31'b0, req_ready}, 1);
      xfer(0, 2, 0, 32'hBFC00004, 0, 2, 32'hDEADBEEF);
      xfer(0, 0, 1, 32'hBFC00003, 0, 0, 32'h80112233);
      xfer(0, 0, 0, 32'hBFC00003, 0, 1, 32'h80112233);
      xfer(1, 1, 0, 32'hBFC00002, 32'h0000ABCD, 0, 0);
      xfer(1, 2, 0, 32'hBFC00001, 32'h12345678, 0, 0);
      xfer(0, 3, 0, 32'hBFC00000, 0, 0, 0);
      xfer(0, 1, 1, 32'hBFC00002, 0, TO, 32'h8001_7FFF);
      xfer(0, 2, 0, 32'hBFC00008, 0, 100, 32'h11111111);
      xfer(0, 1, 1, 32'hBFC00000, 0, 0, 32'h8001_7FFF);
      for (int i = 0; i < 80; i++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = $urandom_range(0, 1) ? 2'b00 : a[1:0] & {1'b1, ~a[2]};
         xfer(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, TO + 2), $urandom);
      end
      req_valid = 1; req_we = 0; req_size = 2; req_addr = 32'hBFC00010;
      @(posedge clk); #1;
      req_valid = 0; waitrequest = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_read", {31'b0, read}, 1);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("midrst_read", {31'b0, read}, 0);
      chk("midrst_ready", {31'b0, req_ready}, 1);
      chk("midrst_addr", address, 0);
      chk("midrst_be", {28'b0, byteenable}, 0);
      cnt_rv = 0;
      for (int i = 0; i < 12; i++) begin
         if (resp_valid || read) cnt_rv++;
         @(posedge clk); #1;
      end
      chk("midrst_no_resp", cnt_rv, 0);
      xfer(0, 2, 0, 32'hBFC00004, 0, 1, 32'hCAFEF00D);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
